// File: rtl/otter_pkg.sv
// Shared types for the fetch-redirect control slice: PC mux select codes,
// redirect-controller states and small helper functions.
package otter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    PCSRC_PC4    = 3'd0,
    PCSRC_JALR   = 3'd1,
    PCSRC_BRANCH = 3'd2,
    PCSRC_JAL    = 3'd3,
    PCSRC_MTVEC  = 3'd4,
    PCSRC_MEPC   = 3'd5
  } pc_src_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2
  } fr_state_t;

  // Fixed redirect priority: JALR > JAL > BRANCH > MRET.
  function automatic pc_src_t redirect_sel(input logic jalr, input logic jal,
                                           input logic br, input logic mret);
    pc_src_t sel;
    sel = PCSRC_PC4;
    if (jalr)      sel = PCSRC_JALR;
    else if (jal)  sel = PCSRC_JAL;
    else if (br)   sel = PCSRC_BRANCH;
    else if (mret) sel = PCSRC_MEPC;
    return sel;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Bundle of EX/hazard/CSR inputs and PC/pipeline control outputs of the
// fetch redirect controller. Optional statistics outputs exist only when
// FETCH_STATS_EN is defined.
interface fetch_redirect_ctrl_if;
  import otter_pkg::*;

  logic            EX_VALID;
  logic            EX_JALR;
  logic            EX_JAL;
  logic            EX_BR_TAKEN;
  logic            EX_MRET;
  logic [XLEN-1:0] EX_PC;
  logic            LOAD_USE_STALL;
  logic            INTR;
  logic            MIE;
  logic [XLEN-1:0] PC_ADDRESS;

  logic [2:0]      PC_SOURCE;
  logic            PC_WRITE;
  logic            IFID_WRITE;
  logic            IFID_FLUSH;
  logic            IDEX_FLUSH;
  logic            TRAP_TAKEN;
  logic [XLEN-1:0] TRAP_EPC;
  logic [XLEN-1:0] FETCH_PC;
`ifdef FETCH_STATS_EN
  logic [XLEN-1:0] STAT_REDIRECTS;
  logic [XLEN-1:0] STAT_STALLS;
  logic [XLEN-1:0] STAT_TRAPS;
`endif

  // Controller side.
  modport master (
    input  EX_VALID, EX_JALR, EX_JAL, EX_BR_TAKEN, EX_MRET, EX_PC,
           LOAD_USE_STALL, INTR, MIE, PC_ADDRESS,
    output PC_SOURCE, PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_FLUSH,
           TRAP_TAKEN, TRAP_EPC, FETCH_PC
`ifdef FETCH_STATS_EN
    , output STAT_REDIRECTS, STAT_STALLS, STAT_TRAPS
`endif
  );

  // Pipeline / PC side.
  modport slave (
    output EX_VALID, EX_JALR, EX_JAL, EX_BR_TAKEN, EX_MRET, EX_PC,
           LOAD_USE_STALL, INTR, MIE, PC_ADDRESS,
    input  PC_SOURCE, PC_WRITE, IFID_WRITE, IFID_FLUSH, IDEX_FLUSH,
           TRAP_TAKEN, TRAP_EPC, FETCH_PC
`ifdef FETCH_STATS_EN
    , input STAT_REDIRECTS, STAT_STALLS, STAT_TRAPS
`endif
  );
endinterface

// File: rtl/fetch_stat_counters.sv
// Three saturating event counters (EX redirects, load-use stall cycles,
// traps taken). Each updates at the edge that closes the counted cycle.
module fetch_stat_counters
  import otter_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            inc_redirect_i,
  input  logic            inc_stall_i,
  input  logic            inc_trap_i,
  output logic [XLEN-1:0] stat_redirects_o,
  output logic [XLEN-1:0] stat_stalls_o,
  output logic [XLEN-1:0] stat_traps_o
);

  logic [XLEN-1:0] redirects_q, stalls_q, traps_q;

  // Counter registers with synchronous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      redirects_q <= '0;
      stalls_q    <= '0;
      traps_q     <= '0;
    end else begin
      if (inc_redirect_i) redirects_q <= sat_inc(redirects_q);
      if (inc_stall_i)    stalls_q    <= sat_inc(stalls_q);
      if (inc_trap_i)     traps_q     <= sat_inc(traps_q);
    end
  end

  assign stat_redirects_o = redirects_q;
  assign stat_stalls_o    = stalls_q;
  assign stat_traps_o     = traps_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: drives the PC mux select/write and IF/ID, ID/EX
// hold/flush from EX redirects, load-use stalls and interrupt entry.
// Interrupt entry holds fetch for DRAIN_CYCLES cycles before selecting MTVEC.
// Optional feature macro: FETCH_STATS_EN (adds saturating event counters).
module fetch_redirect_ctrl
  import otter_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  fetch_redirect_ctrl_if.master bus
);

  fr_state_t       state_q;
  logic [3:0]      drain_cnt_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic            intr_pend_q;

  logic redirect, stall, accept;

  assign redirect = bus.EX_VALID &
                    (bus.EX_JALR | bus.EX_JAL | bus.EX_BR_TAKEN | bus.EX_MRET);
  assign stall    = bus.LOAD_USE_STALL;
  assign accept   = intr_pend_q & bus.MIE & bus.EX_VALID;

  // Control outputs, combinational from state and inputs; reset forces a
  // held, flushed pipeline.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    bus.PC_SOURCE  = PCSRC_PC4;
    bus.PC_WRITE   = 1'b0;
    bus.IFID_WRITE = 1'b0;
    bus.IFID_FLUSH = 1'b1;
    bus.IDEX_FLUSH = 1'b1;
    bus.TRAP_TAKEN = 1'b0;
    if (!RST) begin
      unique case (state_q)
        RUN: begin
          if (redirect) begin
            bus.PC_SOURCE  = redirect_sel(bus.EX_JALR, bus.EX_JAL,
                                          bus.EX_BR_TAKEN, bus.EX_MRET);
            bus.PC_WRITE   = 1'b1;
            bus.IFID_WRITE = 1'b1;
          end else if (stall) begin
            bus.IFID_FLUSH = 1'b0;
          end else if (!accept) begin
            bus.PC_WRITE   = 1'b1;
            bus.IFID_WRITE = 1'b1;
            bus.IFID_FLUSH = 1'b0;
            bus.IDEX_FLUSH = 1'b0;
          end
        end
        DRAIN: ;
        TRAP: begin
          bus.PC_SOURCE  = PCSRC_MTVEC;
          bus.PC_WRITE   = 1'b1;
          bus.IFID_WRITE = 1'b1;
          bus.TRAP_TAKEN = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Controller state machine plus interrupt sampling, epc and fetch-PC trace.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      epc_q       <= '0;
      fetch_pc_q  <= '0;
      intr_pend_q <= 1'b0;
    end else begin
      fetch_pc_q  <= bus.PC_ADDRESS;
      intr_pend_q <= bus.INTR;
      unique case (state_q)
        RUN: begin
          if (!redirect && !stall && accept) begin
            epc_q       <= bus.EX_PC;
            drain_cnt_q <= 4'(DRAIN_CYCLES - 1);
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == '0) state_q <= TRAP;
          else                   drain_cnt_q <= drain_cnt_q - 1'b1;
        end
        TRAP: begin
          intr_pend_q <= 1'b0;
          state_q     <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.TRAP_EPC = epc_q;
  assign bus.FETCH_PC = fetch_pc_q;

`ifdef FETCH_STATS_EN
  logic inc_redirect, inc_stall, inc_trap;

  assign inc_redirect = !RST && (state_q == RUN) && redirect;
  assign inc_stall    = !RST && (state_q == RUN) && !redirect && stall;
  assign inc_trap     = !RST && (state_q == TRAP);

  fetch_stat_counters u_stats (
    .CLK              (CLK),
    .RST              (RST),
    .inc_redirect_i   (inc_redirect),
    .inc_stall_i      (inc_stall),
    .inc_trap_i       (inc_trap),
    .stat_redirects_o (bus.STAT_REDIRECTS),
    .stat_stalls_o    (bus.STAT_STALLS),
    .stat_traps_o     (bus.STAT_TRAPS)
  );
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_fetch_redirect_ctrl;
  import otter_pkg::*;

  localparam int DC = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fetch_redirect_ctrl_if bus ();

  fetch_redirect_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.EX_VALID       = 1'b0;
    bus.EX_JALR        = 1'b0;
    bus.EX_JAL         = 1'b0;
    bus.EX_BR_TAKEN    = 1'b0;
    bus.EX_MRET        = 1'b0;
    bus.EX_PC          = '0;
    bus.LOAD_USE_STALL = 1'b0;
    bus.INTR           = 1'b0;
    bus.MIE            = 1'b0;
    bus.PC_ADDRESS     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.PC_ADDRESS = 32'h0000_0100;
    RST = 1'b1;
    sample();
    checks++;
    if ({bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_WRITE, bus.IFID_FLUSH,
         bus.IDEX_FLUSH, bus.TRAP_TAKEN} !== {3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got src=%0d pw=%b iw=%b f1=%b f2=%b tt=%b required 0 0 0 1 1 0",
               bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_WRITE, bus.IFID_FLUSH,
               bus.IDEX_FLUSH, bus.TRAP_TAKEN);
    end
    tick();
    RST = 1'b0;
    bus.PC_ADDRESS = 32'h0000_0104;
    sample();
    checks++;
    if ({bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_WRITE, bus.IFID_FLUSH,
         bus.IDEX_FLUSH, bus.TRAP_TAKEN} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_idle got src=%0d pw=%b iw=%b f1=%b f2=%b tt=%b required 0 1 1 0 0 0",
               bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_WRITE, bus.IFID_FLUSH,
               bus.IDEX_FLUSH, bus.TRAP_TAKEN);
    end
    checks++;
    if (bus.FETCH_PC !== 32'h0) begin
      errors++;
      $display("FAIL fetch_pc_after_reset got=%h required=00000000", bus.FETCH_PC);
    end
    tick();
    sample();
    checks++;
    if (bus.FETCH_PC !== 32'h0000_0104) begin
      errors++;
      $display("FAIL fetch_pc_delay got=%h required=00000104", bus.FETCH_PC);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if ({bus.STAT_REDIRECTS, bus.STAT_STALLS, bus.STAT_TRAPS} !== 96'h0) begin
      errors++;
      $display("FAIL stats_reset got=%0d/%0d/%0d required=0/0/0",
               bus.STAT_REDIRECTS, bus.STAT_STALLS, bus.STAT_TRAPS);
    end
`endif
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    bus.EX_VALID = 1'b1;
    bus.EX_BR_TAKEN = 1'b1;
    sample();
    checks++;
    if ({bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_FLUSH, bus.IDEX_FLUSH} !==
        {3'd2, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL branch got src=%0d pw=%b f1=%b f2=%b required 2 1 1 1",
               bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_FLUSH, bus.IDEX_FLUSH);
    end
    // Taken-branch flag without a valid EX instruction is no redirect.
    bus.EX_VALID = 1'b0;
    tick();
    sample();
    checks++;
    if ({bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_FLUSH} !== {3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL branch_bubble got src=%0d pw=%b f1=%b required 0 1 0",
               bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_FLUSH);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_priority();
    do_reset();
    bus.EX_VALID = 1'b1;
    bus.EX_JALR = 1'b1;
    bus.EX_JAL = 1'b1;
    bus.LOAD_USE_STALL = 1'b1;
    sample();
    checks++;
    if ({bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_WRITE} !== {3'd1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL prio_jalr got src=%0d pw=%b iw=%b required 1 1 1",
               bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_WRITE);
    end
    tick();
    bus.EX_JALR = 1'b0;
    bus.EX_BR_TAKEN = 1'b1;
    bus.EX_MRET = 1'b1;
    sample();
    checks++;
    if (bus.PC_SOURCE !== 3'd3) begin
      errors++;
      $display("FAIL prio_jal got src=%0d required 3", bus.PC_SOURCE);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    bus.EX_VALID = 1'b1;
    bus.LOAD_USE_STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++;
      if ({bus.PC_WRITE, bus.IFID_WRITE, bus.IDEX_FLUSH, bus.PC_SOURCE} !==
          {1'b0, 1'b0, 1'b1, 3'd0}) begin
        errors++;
        $display("FAIL stall_cycle%0d got pw=%b iw=%b f2=%b src=%0d required 0 0 1 0",
                 i, bus.PC_WRITE, bus.IFID_WRITE, bus.IDEX_FLUSH, bus.PC_SOURCE);
      end
      tick();
    end
    bus.LOAD_USE_STALL = 1'b0;
    sample();
    checks++;
    if ({bus.PC_WRITE, bus.IFID_WRITE, bus.IDEX_FLUSH} !== {1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stall_release got pw=%b iw=%b f2=%b required 1 1 0",
               bus.PC_WRITE, bus.IFID_WRITE, bus.IDEX_FLUSH);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (bus.STAT_STALLS !== 32'd3 || bus.STAT_REDIRECTS !== 32'd0) begin
      errors++;
      $display("FAIL stat_stalls got stalls=%0d redirects=%0d required 3 0",
               bus.STAT_STALLS, bus.STAT_REDIRECTS);
    end
`endif
    idle_inputs();
    tick();
  endtask

  task automatic test_interrupt();
    do_reset();
    bus.MIE = 1'b1;
    bus.INTR = 1'b1;
    bus.EX_VALID = 1'b1;
    bus.EX_PC = 32'h0000_0040;
    sample();  // INTR not yet sampled
    checks++;
    if ({bus.PC_WRITE, bus.IFID_FLUSH, bus.TRAP_TAKEN} !== {1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL intr_sampling got pw=%b f1=%b tt=%b required 1 0 0",
               bus.PC_WRITE, bus.IFID_FLUSH, bus.TRAP_TAKEN);
    end
    tick();
    sample();  // accept cycle
    checks++;
    if ({bus.PC_WRITE, bus.IFID_FLUSH, bus.IDEX_FLUSH, bus.TRAP_TAKEN} !==
        {1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL intr_accept got pw=%b f1=%b f2=%b tt=%b required 0 1 1 0",
               bus.PC_WRITE, bus.IFID_FLUSH, bus.IDEX_FLUSH, bus.TRAP_TAKEN);
    end
    tick();
    // Redirect during drain must be ignored; epc was captured at accept.
    bus.EX_PC = 32'h0000_0080;
    bus.EX_BR_TAKEN = 1'b1;
    for (int i = 0; i < DC; i++) begin
      sample();
      checks++;
      if ({bus.PC_WRITE, bus.IFID_FLUSH, bus.IDEX_FLUSH, bus.TRAP_TAKEN, bus.PC_SOURCE} !==
          {1'b0, 1'b1, 1'b1, 1'b0, 3'd0}) begin
        errors++;
        $display("FAIL intr_drain%0d got pw=%b f1=%b f2=%b tt=%b src=%0d required 0 1 1 0 0",
                 i, bus.PC_WRITE, bus.IFID_FLUSH, bus.IDEX_FLUSH, bus.TRAP_TAKEN,
                 bus.PC_SOURCE);
      end
      tick();
      bus.EX_BR_TAKEN = 1'b0;
    end
    bus.INTR = 1'b0;
    sample();  // trap cycle
    checks++;
    if ({bus.TRAP_TAKEN, bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_FLUSH, bus.IDEX_FLUSH} !==
        {1'b1, 3'd4, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL intr_trap got tt=%b src=%0d pw=%b f1=%b f2=%b required 1 4 1 1 1",
               bus.TRAP_TAKEN, bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_FLUSH,
               bus.IDEX_FLUSH);
    end
    checks++;
    if (bus.TRAP_EPC !== 32'h0000_0040) begin
      errors++;
      $display("FAIL intr_epc got=%h required=00000040", bus.TRAP_EPC);
    end
    tick();
    sample();
    checks++;
    if ({bus.TRAP_TAKEN, bus.PC_WRITE, bus.PC_SOURCE} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL intr_return_run got tt=%b pw=%b src=%0d required 0 1 0",
               bus.TRAP_TAKEN, bus.PC_WRITE, bus.PC_SOURCE);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (bus.STAT_TRAPS !== 32'd1 || bus.STAT_REDIRECTS !== 32'd0) begin
      errors++;
      $display("FAIL stat_traps got traps=%0d redirects=%0d required 1 0",
               bus.STAT_TRAPS, bus.STAT_REDIRECTS);
    end
`endif
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_trap();
    do_reset();
    bus.MIE = 1'b1;
    bus.INTR = 1'b1;
    bus.EX_VALID = 1'b1;
    bus.EX_PC = 32'h0000_0044;
    tick();
    sample();
    checks++;
    if (bus.PC_WRITE !== 1'b0) begin
      errors++;
      $display("FAIL midtrap_accept got pw=%b required 0", bus.PC_WRITE);
    end
    tick();
    bus.INTR = 1'b0;
    RST = 1'b1;
    sample();
    checks++;
    if ({bus.TRAP_TAKEN, bus.PC_WRITE} !== {1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midtrap_in_reset got tt=%b pw=%b required 0 0",
               bus.TRAP_TAKEN, bus.PC_WRITE);
    end
    tick();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      checks++;
      if ({bus.TRAP_TAKEN, bus.PC_WRITE, bus.IFID_FLUSH, bus.PC_SOURCE} !==
          {1'b0, 1'b1, 1'b0, 3'd0}) begin
        errors++;
        $display("FAIL midtrap_abandon%0d got tt=%b pw=%b f1=%b src=%0d required 0 1 0 0",
                 i, bus.TRAP_TAKEN, bus.PC_WRITE, bus.IFID_FLUSH, bus.PC_SOURCE);
      end
      tick();
    end
    bus.EX_MRET = 1'b1;
    sample();
    checks++;
    if ({bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_FLUSH} !== {3'd5, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL mret got src=%0d pw=%b f1=%b required 5 1 1",
               bus.PC_SOURCE, bus.PC_WRITE, bus.IFID_FLUSH);
    end
    idle_inputs();
    tick();
  endtask

  // Randomized run: the model tracks "cycles until the MTVEC fetch" as a
  // plain countdown and applies the controller rules cycle by cycle.
  task automatic test_random();
    bit          m_pend = 0;
    int          m_until_trap = 0;   // 0: running, k>1: drain, 1: trap cycle
    logic [31:0] m_epc = 0, m_fetch = 0;
    int          m_redirects = 0, m_stalls = 0, m_traps = 0;
    logic [2:0]  e_src;
    bit          e_pw, e_iw, e_f1, e_f2, e_tt, iw_known;
    bit          r_rst, r_valid, r_jalr, r_jal, r_br, r_mret, r_stall, r_intr, r_mie;
    logic [31:0] r_expc, r_pca;
    r_intr = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_rst   = ($urandom_range(63) == 0);
      r_valid = ($urandom_range(3) != 0);
      r_jalr  = ($urandom_range(11) == 0);
      r_jal   = ($urandom_range(11) == 0);
      r_br    = ($urandom_range(7) == 0);
      r_mret  = ($urandom_range(15) == 0);
      r_stall = ($urandom_range(5) == 0);
      if ($urandom_range(15) == 0) r_intr = !r_intr;
      r_mie   = ($urandom_range(3) != 0);
      r_expc  = $urandom() & 32'hFFFF_FFFC;
      r_pca   = $urandom() & 32'hFFFF_FFFC;
      RST = r_rst;
      bus.EX_VALID = r_valid;  bus.EX_JALR = r_jalr;  bus.EX_JAL = r_jal;
      bus.EX_BR_TAKEN = r_br;  bus.EX_MRET = r_mret;  bus.EX_PC = r_expc;
      bus.LOAD_USE_STALL = r_stall;  bus.INTR = r_intr;  bus.MIE = r_mie;
      bus.PC_ADDRESS = r_pca;

      e_src = 3'd0; e_pw = 0; e_iw = 0; e_f1 = 1; e_f2 = 1; e_tt = 0; iw_known = 1;
      if (r_rst) begin
        // held and flushed
      end else if (m_until_trap > 1) begin
        iw_known = 0;
      end else if (m_until_trap == 1) begin
        e_src = 3'd4; e_pw = 1; e_tt = 1; iw_known = 0;
      end else if (r_valid && (r_jalr || r_jal || r_br || r_mret)) begin
        e_src = r_jalr ? 3'd1 : r_jal ? 3'd3 : r_br ? 3'd2 : 3'd5;
        e_pw = 1; e_iw = 1;
      end else if (r_stall) begin
        e_f1 = 0;
      end else if (m_pend && r_mie && r_valid) begin
        iw_known = 0;
      end else begin
        e_pw = 1; e_iw = 1; e_f1 = 0; e_f2 = 0;
      end

      sample();
      checks++;
      if (bus.PC_SOURCE !== e_src) begin
        errors++;
        $display("FAIL rnd_pc_source cyc=%0d got=%0d required=%0d", cyc, bus.PC_SOURCE, e_src);
      end
      checks++;
      if ({bus.PC_WRITE, bus.IFID_FLUSH, bus.IDEX_FLUSH, bus.TRAP_TAKEN} !==
          {e_pw, e_f1, e_f2, e_tt}) begin
        errors++;
        $display("FAIL rnd_ctrl cyc=%0d got pw/f1/f2/tt=%b%b%b%b required=%b%b%b%b", cyc,
                 bus.PC_WRITE, bus.IFID_FLUSH, bus.IDEX_FLUSH, bus.TRAP_TAKEN,
                 e_pw, e_f1, e_f2, e_tt);
      end
      if (iw_known) begin
        checks++;
        if (bus.IFID_WRITE !== e_iw) begin
          errors++;
          $display("FAIL rnd_ifid_write cyc=%0d got=%b required=%b", cyc, bus.IFID_WRITE, e_iw);
        end
      end
      if (e_tt) begin
        checks++;
        if (bus.TRAP_EPC !== m_epc) begin
          errors++;
          $display("FAIL rnd_trap_epc cyc=%0d got=%h required=%h", cyc, bus.TRAP_EPC, m_epc);
        end
      end
      checks++;
      if (bus.FETCH_PC !== m_fetch) begin
        errors++;
        $display("FAIL rnd_fetch_pc cyc=%0d got=%h required=%h", cyc, bus.FETCH_PC, m_fetch);
      end
`ifdef FETCH_STATS_EN
      checks++;
      if (bus.STAT_REDIRECTS !== 32'(m_redirects) || bus.STAT_STALLS !== 32'(m_stalls) ||
          bus.STAT_TRAPS !== 32'(m_traps)) begin
        errors++;
        $display("FAIL rnd_stats cyc=%0d got=%0d/%0d/%0d required=%0d/%0d/%0d", cyc,
                 bus.STAT_REDIRECTS, bus.STAT_STALLS, bus.STAT_TRAPS,
                 m_redirects, m_stalls, m_traps);
      end
`endif

      // Advance the model across the coming edge.
      if (r_rst) begin
        m_pend = 0; m_until_trap = 0; m_epc = 0; m_fetch = 0;
        m_redirects = 0; m_stalls = 0; m_traps = 0;
      end else begin
        m_fetch = r_pca;
        if (m_until_trap > 1) begin
          m_until_trap--;
          m_pend = r_intr;
        end else if (m_until_trap == 1) begin
          m_until_trap = 0;
          m_pend = 0;
          m_traps++;
        end else begin
          if (r_valid && (r_jalr || r_jal || r_br || r_mret)) m_redirects++;
          else if (r_stall) m_stalls++;
          else if (m_pend && r_mie && r_valid) begin
            m_epc = r_expc;
            m_until_trap = DC + 1;
          end
          m_pend = r_intr;
        end
      end
      tick();
    end
    RST = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_branch();
    test_priority();
    test_stall();
    test_interrupt();
    test_reset_mid_trap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Control partner of the PC/next-PC mux, on the other side of its interface. It drives the mux select `PC_SOURCE` and the `PC_WRITE` enable, and consumes the fetch address the PC produces. It resolves EX-stage branch, jump and mret redirects, load-use stalls and interrupt entry, and drives the IF/ID and ID/EX flush/hold controls. It sits between the EX stage, the hazard unit, the CSR unit and the PC block.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 2: cycles the fetch side is held before `MTVEC` is selected, so MEM/WB instructions retire (range 1–15).

Ports:
- `CLK`  in  1  rising-edge clock
- `RST`  in  1  synchronous, active-high reset
- `EX_VALID`  in  1  EX stage holds a real instruction
- `EX_JALR`, `EX_JAL`, `EX_BR_TAKEN`, `EX_MRET`  in  1 each  EX redirect requests
- `EX_PC`  in  32  PC of the EX instruction
- `LOAD_USE_STALL`  in  1  hazard-unit stall request
- `INTR`  in  1  level interrupt request
- `MIE`  in  1  global interrupt enable (mstatus.MIE)
- `PC_ADDRESS`  in  32  current fetch address from the PC
- `PC_SOURCE`  out  3  mux select: 0 PC+4, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC, 5 MEPC
- `PC_WRITE`  out  1  PC load enable
- `IFID_WRITE`  out  1  IF/ID register enable
- `IFID_FLUSH`, `IDEX_FLUSH`  out  1 each  insert a bubble
- `TRAP_TAKEN`  out  1  one-cycle pulse; CSR unit writes mepc/mcause
- `TRAP_EPC`  out  32  mepc value, valid while `TRAP_TAKEN`
- `FETCH_PC`  out  32  registered `PC_ADDRESS`, for IF/ID debug and trace

## Operation
States:
- `RUN`
- `DRAIN`
- `TRAP`

Interrupt pending:
- `intr_pend` register loads `INTR` every cycle (1-cycle sampling latency).
- Cleared in the `TRAP` cycle.

`RUN`, evaluated in priority order:
1. **EX redirect** (`EX_VALID` and any redirect input):
   - Select priority JALR(1) > JAL(3) > BRANCH(2) > MRET(5).
   - `PC_WRITE`=1, `IFID_FLUSH`=1, `IDEX_FLUSH`=1, `IFID_WRITE`=1.
   - `LOAD_USE_STALL` is ignored this cycle.
   - Interrupt acceptance is deferred.
2. **Load-use stall**: `PC_WRITE`=0, `IFID_WRITE`=0, `IDEX_FLUSH`=1, `PC_SOURCE`=0.
3. **Interrupt accept** (`intr_pend` & `MIE` & `EX_VALID`):
   - Capture `EX_PC` into the epc register.
   - Load the drain counter with `DRAIN_CYCLES`-1.
   - `PC_WRITE`=0, `IFID_FLUSH`=1, `IDEX_FLUSH`=1.
   - Go to `DRAIN`.
4. **Default**: `PC_SOURCE`=0, `PC_WRITE`=1, `IFID_WRITE`=1, flushes 0.

`DRAIN`:
- `PC_WRITE`=0, `IFID_FLUSH`=1, `IDEX_FLUSH`=1.
- All EX/stall inputs are ignored.
- Counter decrements; at 0, go to `TRAP`.

`TRAP`:
- `PC_SOURCE`=4, `PC_WRITE`=1, `TRAP_TAKEN`=1, `TRAP_EPC`=epc.
- Both flushes = 1.
- Go to `RUN`.

An mret in EX is an ordinary redirect (select 5). Restoring MIE is the CSR unit's job.

## Timing
- `PC_SOURCE`, `PC_WRITE`, `IFID_WRITE` and the flushes are combinational from state and inputs; the PC and pipeline registers consume them at the same rising edge.
- Redirect penalty: 2 bubbles (IF/ID and ID/EX squashed).
- Interrupt latency from `INTR` assertion to `MTVEC` fetch: 1 (sampling) + accept cycle + `DRAIN_CYCLES`. The `TRAP` cycle itself selects `MTVEC`.
- `FETCH_PC` is `PC_ADDRESS` delayed by one cycle.
- While `RST`=1:
  - Outputs: `PC_SOURCE`=0, `PC_WRITE`=0, `IFID_WRITE`=0, `IFID_FLUSH`=1, `IDEX_FLUSH`=1, `TRAP_TAKEN`=0.
  - Next state: `RUN`; `intr_pend`, epc, counter, `TRAP_EPC` and `FETCH_PC` load 0.
- `RST` mid-`DRAIN`/`TRAP`: the trap is abandoned; no `TRAP_TAKEN` pulse.
- `intr_pend` with `MIE`=0: stays pending, no effect.
- Interrupt arriving with an EX bubble (`EX_VALID`=0): waits for the next valid EX instruction.

## Configuration
- `FETCH_STATS_EN` defined:
  - Adds outputs `STAT_REDIRECTS` [31:0] (EX redirects, not traps), `STAT_STALLS` [31:0] (load-use stall cycles) and `STAT_TRAPS` [31:0].
  - All three are saturating, 0 on reset, and update at the clock edge following the counted cycle.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
Shared package `otter_pkg`:
- `pc_src_t` enum (`PCSRC_PC4`=0, `JALR`=1, `BRANCH`=2, `JAL`=3, `MTVEC`=4, `MEPC`=5).
- `fr_state_t` enum (`RUN`, `DRAIN`, `TRAP`).

Sub-module `fetch_stat_counters` holds the three saturating counters and is instantiated only under `FETCH_STATS_EN`.

## Test plan
- **Reset**: `RST`=1 one cycle, then idle → `PC_SOURCE`=0, `PC_WRITE`=1, `IFID_WRITE`=1, flushes 0 from the first post-reset cycle.
- **Branch**: `EX_VALID`=1, `EX_BR_TAKEN`=1 → same cycle `PC_SOURCE`=2, `PC_WRITE`=1, `IFID_FLUSH`=`IDEX_FLUSH`=1.
- **Priority**: `EX_JALR`=`EX_JAL`=`LOAD_USE_STALL`=1 together → `PC_SOURCE`=1, `PC_WRITE`=1.
- **Stall**: `LOAD_USE_STALL`=1 for 3 cycles → `PC_WRITE`=0 and `IFID_WRITE`=0 for exactly 3 cycles, `IDEX_FLUSH`=1; `STAT_STALLS`=3 when enabled.
- **Interrupt**: `DRAIN_CYCLES`=2, `INTR`=1, `MIE`=1, `EX_PC`=0x0000_0040 →
  - cycle after sampling: accept;
  - 2 `DRAIN` cycles with `PC_WRITE`=0;
  - then `TRAP_TAKEN`=1, `TRAP_EPC`=0x40, `PC_SOURCE`=4.
- **Reset mid-trap, then mret**:
  - `RST` asserted during `DRAIN` → no `TRAP_TAKEN`, state `RUN`.
  - Later, `EX_MRET`=1 → `PC_SOURCE`=5, `PC_WRITE`=1.
